sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single Avalon-MM slave of the FPGA-side SDRAM controller among NUM_REQ fabric masters.
//  Example masters: HPS bridge, display refresher, DMA.
//  Round-robin arbitration with bounded grant hold; pipelined reads routed back by an in-order tag FIFO.
//  Sits between the fabric masters and the SDRAM controller that drives the sdram_wire_* pins.
// PARAMETERS
//  NUM_REQ      3   number of requesting masters (2..8)
//  ADDR_W       25  word address width (16-bit words, 64 MB)
//  DATA_W       16  data width; byteenable width = DATA_W/8
//  MAX_PENDING  8   read tag FIFO depth (power of 2); max outstanding reads
//  MAX_HOLD     4   max accepted commands per grant while others wait
// PORTS
//  clk_clk          in   1                  system clock
//  reset_reset_n    in   1                  async active-low reset
//  m_address        in   NUM_REQ*ADDR_W     per-master address, master i at slice [i*ADDR_W +: ADDR_W]
//  m_read           in   NUM_REQ            per-master read request
//  m_write          in   NUM_REQ            per-master write request
//  m_writedata      in   NUM_REQ*DATA_W     per-master write data
//  m_byteenable     in   NUM_REQ*DATA_W/8   per-master byte enables
//  m_waitrequest    out  NUM_REQ            per-master stall
//  m_readdata       out  DATA_W             broadcast read data
//  m_readdatavalid  out  NUM_REQ            one-hot read data valid
//  s_address        out  ADDR_W             to SDRAM controller
//  s_read           out  1                  to SDRAM controller
//  s_write          out  1                  to SDRAM controller
//  s_writedata      out  DATA_W             to SDRAM controller
//  s_byteenable     out  DATA_W/8           to SDRAM controller
//  s_waitrequest    in   1                  from SDRAM controller
//  s_readdata       in   DATA_W             from SDRAM controller
//  s_readdatavalid  in   1                  from SDRAM controller
//  err_o            out  1                  sticky protocol error
// BEHAVIOUR
//  Reset values
//   - State IDLE, no grant, rr pointer=0, hold count=0, FIFO empty, err_o=0.
//   - s_read=0, s_write=0, m_waitrequest=all 1, m_readdatavalid=0.
//   - Mid-operation reset drops outstanding reads; late s_readdatavalid after reset sets err_o.
//  States
//   - IDLE: any m_read|m_write -> GRANT; winner = first requester at/after rr pointer; grant registered.
//   - GRANT: s_* = granted master's signals, combinational.
//     m_waitrequest[g] = s_waitrequest | read_blocked; all others held at 1.
//   - Grant timing: command reaches s_* 1 cycle after the request in IDLE; back-to-back while held.
//  Accept / release
//   - Accept = (s_read|s_write) & ~s_waitrequest; hold count +1 per accept.
//   - Release the grant after an accept when master g drops its request,
//     or when hold count==MAX_HOLD and another master is requesting.
//   - On release: rr pointer = g+1 (mod NUM_REQ), hold=0.
//     Next state GRANT to the new winner if any request remains, else IDLE.
//     Release costs no idle cycle.
//   - Before any accept, the grant is never released, even if g deasserts (Avalon rule: command stays until accepted).
//  Read routing
//   - Read accept pushes g into the tag FIFO.
//   - s_readdatavalid pops the head; m_readdatavalid[head]=1 the same cycle.
//   - m_readdata = s_readdata, zero latency.
//   - FIFO full: read_blocked=1, s_read forced 0. Decided: blocked even if a pop occurs the same cycle.
//     Writes are unaffected by a full FIFO.
//   - Simultaneous push and pop when not full: count unchanged.
//  Errors (sticky err_o until reset)
//   - s_readdatavalid while FIFO empty: no m_readdatavalid, err_o set.
//   - m_read&m_write on the granted master: treated as write, err_o set.
//  Widths
//   - Tag width = $clog2(NUM_REQ); FIFO pointers $clog2(MAX_PENDING)+1 bits, wrap via MSB compare.
// STRUCTURE
//  Package sdram_arb_pkg: arb_state_t {IDLE,GRANT}, tag_t, default parameter constants.
//  Sub-module sdram_arb_tag_fifo: sync FIFO of tag_t with push/pop/full/empty; arbiter + mux in top.
// TESTING
//  1. Master 0 single read, s_waitrequest=0, slave data 0xBEEF after 3 cycles
//     -> s_read 1 cycle after m_read; m_readdatavalid=3'b001, m_readdata=0xBEEF.
//  2. All 3 masters hold writes continuously, MAX_HOLD=4, waitrequest=0
//     -> grant order 0,1,2,0; exactly 4 accepts per grant.
//  3. Master 1 write with s_waitrequest=1 for 5 cycles
//     -> s_write stable, addr/data unchanged; grant not released; accept on cycle 6.
//  4. 8 reads from master 2, no readdatavalid
//     -> 9th read stalled (s_read=0); a write from master 2 still accepted.
//     -> Return 8 valids -> m_readdatavalid[2] x8.
//  5. Interleaved reads m0,m1,m0; responses in order
//     -> one-hot valids 001,010,001.
//     -> Then an extra s_readdatavalid -> err_o=1, no valid.
//  6. reset_reset_n low for 1 cycle with 3 reads pending
//     -> all outputs at reset values immediately; FIFO empty after release.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and defaults for the SDRAM port arbiter
package sdram_arb_pkg;

    localparam int DEF_NUM_REQ     = 3;
    localparam int DEF_ADDR_W      = 25;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_MAX_PENDING = 8;
    localparam int DEF_MAX_HOLD    = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef logic [$clog2(DEF_NUM_REQ)-1:0] tag_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// rtl/sdram_arb_tag_fifo.sv - in-order FIFO of master tags for outstanding reads
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_PENDING,
    parameter int TAG_W = $bits(tag_t)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_tag;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin arbiter sharing one SDRAM Avalon-MM slave
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MAX_PENDING = DEF_MAX_PENDING,
    parameter int MAX_HOLD    = DEF_MAX_HOLD
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic [NUM_REQ*ADDR_W-1:0]     m_address,
    input  logic [NUM_REQ-1:0]            m_read,
    input  logic [NUM_REQ-1:0]            m_write,
    input  logic [NUM_REQ*DATA_W-1:0]     m_writedata,
    input  logic [NUM_REQ*(DATA_W/8)-1:0] m_byteenable,
    output logic [NUM_REQ-1:0]            m_waitrequest,
    output logic [DATA_W-1:0]             m_readdata,
    output logic [NUM_REQ-1:0]            m_readdatavalid,
    output logic [ADDR_W-1:0]             s_address,
    output logic                          s_read,
    output logic                          s_write,
    output logic [DATA_W-1:0]             s_writedata,
    output logic [DATA_W/8-1:0]           s_byteenable,
    input  logic                          s_waitrequest,
    input  logic [DATA_W-1:0]             s_readdata,
    input  logic                          s_readdatavalid,
    output logic                          err_o
);

    localparam int TAG_W  = $clog2(NUM_REQ);
    localparam int BE_W   = DATA_W / 8;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state, state_nxt;
    logic [TAG_W-1:0]  grant, grant_nxt;
    logic [TAG_W-1:0]  rr_ptr, rr_ptr_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [TAG_W-1:0]  fifo_head;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant_mask;
    logic g_read, g_write, read_blocked, accept, release_grant, others_req;
    logic fifo_push, fifo_pop, fifo_full, fifo_empty, err_nxt;

    function automatic logic [TAG_W-1:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                                     input logic [TAG_W-1:0]   start);
        logic [TAG_W-1:0] w;
        int idx;
        w = start;
        // Walk backwards so the requester nearest the pointer is written last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % NUM_REQ;
            if (r[idx]) begin
                w = TAG_W'(idx);
            end
        end
        return w;
    endfunction

    assign req        = m_read | m_write;
    assign grant_mask = NUM_REQ'(1) << grant;
    assign others_req = |(req & ~grant_mask);
    assign g_read     = (state == GRANT) & m_read[grant];
    assign g_write    = (state == GRANT) & m_write[grant];
    assign accept     = (s_read | s_write) & ~s_waitrequest;
    assign fifo_push  = accept & s_read;
    assign fifo_pop   = s_readdatavalid & ~fifo_empty;
    assign m_readdata = s_readdata;
    assign err_nxt    = err_o | (s_readdatavalid & fifo_empty) | (g_read & g_write);

    always_comb begin
        s_address     = m_address[int'(grant)*ADDR_W +: ADDR_W];
        s_writedata   = m_writedata[int'(grant)*DATA_W +: DATA_W];
        s_byteenable  = m_byteenable[int'(grant)*BE_W +: BE_W];
        // A read+write collision is issued as the write.
        s_write       = g_write;
        read_blocked  = g_read & ~g_write & fifo_full;
        s_read        = g_read & ~g_write & ~fifo_full;
        m_waitrequest = '1;
        if (state == GRANT) begin
            m_waitrequest[grant] = s_waitrequest | read_blocked;
        end
    end

    always_comb begin
        m_readdatavalid = '0;
        if (fifo_pop) begin
            m_readdatavalid[fifo_head] = 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        rr_ptr_nxt    = rr_ptr;
        hold_nxt      = hold_cnt;
        release_grant = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                    grant_nxt = pick_winner(req, rr_ptr);
                end
            end
            GRANT: begin
                if (accept && hold_cnt != HOLD_MAX) begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
                // Never release before the first accept: an Avalon command must stay until taken.
                if (accept && hold_cnt >= HOLD_LAST && others_req) begin
                    release_grant = 1'b1;
                end else if (hold_cnt != '0 && !req[grant]) begin
                    release_grant = 1'b1;
                end
                if (release_grant) begin
                    rr_ptr_nxt = TAG_W'(wrap_inc(int'(grant), NUM_REQ));
                    hold_nxt   = '0;
                    grant_nxt  = pick_winner(req, rr_ptr_nxt);
                    state_nxt  = (|req) ? GRANT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            err_o    <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            rr_ptr   <= rr_ptr_nxt;
            hold_cnt <= hold_nxt;
            err_o    <= err_nxt;
        end
    end

    sdram_arb_tag_fifo #(
        .DEPTH (MAX_PENDING),
        .TAG_W (TAG_W)
    ) u_tag_fifo (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .push     (fifo_push),
        .push_tag (grant),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

    localparam int NR = 3;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int BW = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic [NR*AW-1:0] m_address;
    logic [NR-1:0]    m_read, m_write;
    logic [NR*DW-1:0] m_writedata;
    logic [NR*BW-1:0] m_byteenable;
    logic [NR-1:0]    m_waitrequest;
    logic [DW-1:0]    m_readdata;
    logic [NR-1:0]    m_readdatavalid;
    logic [AW-1:0]    s_address;
    logic             s_read, s_write;
    logic [DW-1:0]    s_writedata;
    logic [BW-1:0]    s_byteenable;
    logic             s_waitrequest;
    logic [DW-1:0]    s_readdata;
    logic             s_readdatavalid;
    logic             err_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          m;
        logic [24:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
        logic [24:0] exp_addr;
        logic [15:0] exp_data;
        logic [1:0]  exp_be;
        logic [2:0]  exp_wait;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    sdram_port_arbiter dut (
        .clk_clk         (clk),
        .reset_reset_n   (rst_n),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .s_address       (s_address),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_byteenable    (s_byteenable),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .err_o           (err_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic set_master(input int m, input logic [24:0] a, input logic [15:0] d, input logic [1:0] be);
        m_address[m*AW +: AW]   = a;
        m_writedata[m*DW +: DW] = d;
        m_byteenable[m*BW +: BW] = be;
    endtask

    task automatic access(input int m, input bit wr, input logic [24:0] a);
        int budget;
        set_master(m, a, 16'h0, 2'b11);
        if (wr) m_write[m] = 1'b1;
        else    m_read[m]  = 1'b1;
        budget = 20;
        @(negedge clk);
        while (m_waitrequest[m] === 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_checks++;
        if (budget == 0) begin
            n_errors++;
            $display("FAIL access_timeout m%0d: waitrequest got 1, expected 0", m);
        end
        cyc();
        m_read[m]  = 1'b0;
        m_write[m] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] ew;
        logic [2:0] exp_v [3];
        int exp_m;

        vecs[0] = '{0, 25'h0000123, 16'hA5A5, 2'b11, 25'h0000123, 16'hA5A5, 2'b11, 3'b110};
        vecs[1] = '{1, 25'h1FFFFFF, 16'hFFFF, 2'b01, 25'h1FFFFFF, 16'hFFFF, 2'b01, 3'b101};
        vecs[2] = '{2, 25'h0000000, 16'h0000, 2'b10, 25'h0000000, 16'h0000, 2'b10, 3'b011};
        vecs[3] = '{1, 25'h0AAAAAA, 16'h5A5A, 2'b00, 25'h0AAAAAA, 16'h5A5A, 2'b00, 3'b101};

        rst_n = 1'b0;
        m_address = '0; m_read = '0; m_write = '0; m_writedata = '0; m_byteenable = '0;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_read", s_read, 0);
        chk("rst_s_write", s_write, 0);
        chk("rst_waitreq", m_waitrequest, 3'b111);
        chk("rst_rdvalid", m_readdatavalid, 0);
        chk("rst_err", err_o, 0);
        cyc();
        rst_n = 1'b1;

        // Single read from master 0, data returned three cycles later
        set_master(0, 25'h0000040, 16'h0, 2'b11);
        m_read[0] = 1'b1;
        @(negedge clk);
        chk("t1_idle_s_read", s_read, 0);
        @(negedge clk);
        chk("t1_s_read", s_read, 1);
        chk("t1_s_address", s_address, 25'h0000040);
        chk("t1_waitreq", m_waitrequest, 3'b110);
        cyc();
        m_read[0] = 1'b0;
        cyc();
        cyc();
        s_readdatavalid = 1'b1;
        s_readdata = 16'hBEEF;
        @(negedge clk);
        chk("t1_rdvalid", m_readdatavalid, 3'b001);
        chk("t1_readdata", m_readdata, 16'hBEEF);
        cyc();
        s_readdatavalid = 1'b0;
        @(negedge clk);
        chk("t1_err", err_o, 0);

        // Table of single writes: mux routing per master
        for (int i = 0; i < 4; i++) begin
            cyc();
            set_master(vecs[i].m, vecs[i].addr, vecs[i].data, vecs[i].be);
            m_write[vecs[i].m] = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d_idle_write", i), s_write, 0);
            chk($sformatf("v%0d_idle_wait", i), m_waitrequest, 3'b111);
            @(negedge clk);
            chk($sformatf("v%0d_s_write", i), s_write, 1);
            chk($sformatf("v%0d_addr", i), s_address, vecs[i].exp_addr);
            chk($sformatf("v%0d_data", i), s_writedata, vecs[i].exp_data);
            chk($sformatf("v%0d_be", i), s_byteenable, vecs[i].exp_be);
            chk($sformatf("v%0d_wait", i), m_waitrequest, vecs[i].exp_wait);
            cyc();
            m_write = '0;
            cyc();
        end

        // All three masters write continuously: 4 accepts per grant, order 0,1,2,0
        apply_reset();
        for (int m = 0; m < NR; m++) begin
            set_master(m, 25'h100 + 25'(m), 16'h1000 + 16'(m), 2'b11);
        end
        m_write = 3'b111;
        @(negedge clk);
        chk("t2_idle_write", s_write, 0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp_m = (k / 4) % NR;
            ew = ~(3'b001 << exp_m);
            chk($sformatf("t2_k%0d_write", k), s_write, 1);
            chk($sformatf("t2_k%0d_addr", k), s_address, 25'h100 + 25'(exp_m));
            chk($sformatf("t2_k%0d_wait", k), m_waitrequest, ew);
        end
        cyc();
        m_write = '0;

        // Master 1 write stalled 5 cycles while master 0 also requests
        apply_reset();
        s_waitrequest = 1'b1;
        set_master(1, 25'h00ABCDE, 16'h1234, 2'b11);
        m_write[1] = 1'b1;
        @(negedge clk);
        cyc();
        set_master(0, 25'h0000777, 16'h7777, 2'b11);
        m_write[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("t3_stall%0d_write", k), s_write, 1);
            chk($sformatf("t3_stall%0d_addr", k), s_address, 25'h00ABCDE);
            chk($sformatf("t3_stall%0d_data", k), s_writedata, 16'h1234);
            chk($sformatf("t3_stall%0d_wait", k), m_waitrequest, 3'b111);
            cyc();
        end
        s_waitrequest = 1'b0;
        @(negedge clk);
        chk("t3_accept_addr", s_address, 25'h00ABCDE);
        chk("t3_accept_wait", m_waitrequest, 3'b101);
        cyc();
        m_write[1] = 1'b0;
        @(negedge clk);
        chk("t3_release_write", s_write, 0);
        cyc();
        @(negedge clk);
        chk("t3_m0_addr", s_address, 25'h0000777);
        chk("t3_m0_data", s_writedata, 16'h7777);
        chk("t3_m0_wait", m_waitrequest, 3'b110);
        cyc();
        m_write[0] = 1'b0;
        cyc();

        // Eight reads from master 2 fill the tag FIFO; ninth stalls, write still passes
        set_master(2, 25'h0000200, 16'hCAFE, 2'b11);
        m_read[2] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            cyc();
            @(negedge clk);
            chk($sformatf("t4_read%0d", k), s_read, 1);
        end
        cyc();
        s_readdatavalid = 1'b1;
        s_readdata = 16'h0100;
        @(negedge clk);
        chk("t4_full_s_read", s_read, 0);
        chk("t4_full_wait", m_waitrequest, 3'b111);
        chk("t4_full_pop_valid", m_readdatavalid, 3'b100);
        cyc();
        s_readdatavalid = 1'b0;
        m_read[2] = 1'b0;
        m_write[2] = 1'b1;
        @(negedge clk);
        chk("t4_write_s_write", s_write, 1);
        chk("t4_write_wait", m_waitrequest, 3'b011);
        cyc();
        m_write[2] = 1'b0;
        for (int k = 1; k < 8; k++) begin
            s_readdatavalid = 1'b1;
            s_readdata = 16'h0100 + 16'(k);
            @(negedge clk);
            chk($sformatf("t4_ret%0d_valid", k), m_readdatavalid, 3'b100);
            chk($sformatf("t4_ret%0d_data", k), m_readdata, 16'h0100 + 16'(k));
            cyc();
        end
        s_readdatavalid = 1'b0;
        @(negedge clk);
        chk("t4_err", err_o, 0);
        cyc();

        // Interleaved reads m0,m1,m0 returned in order, then a stray valid
        access(0, 1'b0, 25'h10);
        access(1, 1'b0, 25'h11);
        access(0, 1'b0, 25'h12);
        exp_v[0] = 3'b001;
        exp_v[1] = 3'b010;
        exp_v[2] = 3'b001;
        for (int k = 0; k < 3; k++) begin
            s_readdatavalid = 1'b1;
            s_readdata = 16'h00C0 + 16'(k);
            @(negedge clk);
            chk($sformatf("t5_ret%0d_valid", k), m_readdatavalid, exp_v[k]);
            chk($sformatf("t5_ret%0d_data", k), m_readdata, 16'h00C0 + 16'(k));
            chk($sformatf("t5_ret%0d_err", k), err_o, 0);
            cyc();
        end
        @(negedge clk);
        chk("t5_extra_valid", m_readdatavalid, 3'b000);
        cyc();
        s_readdatavalid = 1'b0;
        @(negedge clk);
        chk("t5_err_set", err_o, 1);
        cyc();

        // Reset for one cycle with three reads pending and a read on the bus
        access(0, 1'b0, 25'h20);
        access(0, 1'b0, 25'h21);
        access(0, 1'b0, 25'h22);
        s_waitrequest = 1'b1;
        set_master(1, 25'h30, 16'h0, 2'b11);
        m_read[1] = 1'b1;
        cyc();
        @(negedge clk);
        chk("t6_pre_s_read", s_read, 1);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_s_read", s_read, 0);
        chk("t6_rst_s_write", s_write, 0);
        chk("t6_rst_wait", m_waitrequest, 3'b111);
        chk("t6_rst_rdvalid", m_readdatavalid, 0);
        chk("t6_rst_err", err_o, 0);
        cyc();
        rst_n = 1'b1;
        m_read[1] = 1'b0;
        s_waitrequest = 1'b0;
        cyc();
        s_readdatavalid = 1'b1;
        s_readdata = 16'hDEAD;
        @(negedge clk);
        chk("t6_late_valid", m_readdatavalid, 3'b000);
        cyc();
        s_readdatavalid = 1'b0;
        @(negedge clk);
        chk("t6_late_err", err_o, 1);

        // Read and write together on the granted master: issued as write, error flagged
        apply_reset();
        @(negedge clk);
        chk("t7_err_clear", err_o, 0);
        cyc();
        set_master(1, 25'h333, 16'h3333, 2'b11);
        m_read[1] = 1'b1;
        m_write[1] = 1'b1;
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("t7_s_write", s_write, 1);
        chk("t7_s_read", s_read, 0);
        cyc();
        m_read[1] = 1'b0;
        m_write[1] = 1'b0;
        @(negedge clk);
        chk("t7_err_set", err_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
